// File: rtl/key_dir_filter.sv
// key_dir_filter: per-frame keycode debounce with hold qualification, reversal reject and post-commit cooldown.
// Define KEY_STICKY_EN to keep the last committed direction when all keys are released.
module key_dir_filter #(
    parameter int          HOLD_FRAMES = 2,
    parameter int          COOLDOWN    = 4,
    parameter logic [15:0] KEY_UP      = 16'h001A,
    parameter logic [15:0] KEY_DOWN    = 16'h0016,
    parameter logic [15:0] KEY_LEFT    = 16'h0004,
    parameter logic [15:0] KEY_RIGHT   = 16'h0007
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [15:0] keycode_raw,
    output logic [15:0] key,
    output logic [1:0]  dir,
    output logic        dir_valid,
    output logic        changed,
    output logic        reject
);
    typedef enum logic [1:0] {IDLE, ACTIVE, COOL} state_t;
    state_t      state_q, state_d;
    logic [15:0] k1_q, k2_q, key_q, key_d, cand_key;
    logic [2:0]  cand_q, cand_d, cls;
    logic [3:0]  cnt_q, cnt_d, cd_q, cd_d;
    logic [1:0]  dir_q, dir_d;
    logic        valid_q, valid_d, changed_q, reject_q, reject_d;
    logic        qual, qual_evt, is_dir, same, opp, commit, release_evt;
    // Class encoding: bit 2 marks a direction, bits 1:0 are the dir code, 3'b000 is NONE.
    always_comb begin
        cls = (k2_q == KEY_UP)    ? 3'b100 :
              (k2_q == KEY_DOWN)  ? 3'b101 :
              (k2_q == KEY_LEFT)  ? 3'b110 :
              (k2_q == KEY_RIGHT) ? 3'b111 : 3'b000;
        cand_d   = cls;
        cnt_d    = 4'd1;
        if (cls == cand_q) begin
            cand_d = cand_q;
            cnt_d  = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
        end
        cand_key = cand_q[1] ? (cand_q[0] ? KEY_RIGHT : KEY_LEFT) : (cand_q[0] ? KEY_DOWN : KEY_UP);
    end
    assign qual     = cnt_q >= 4'(HOLD_FRAMES);
    assign qual_evt = cnt_q == 4'(HOLD_FRAMES);
    assign is_dir   = cand_q[2];
    assign same     = cand_q[1:0] == dir_q;
    assign opp      = cand_q[1:0] == (dir_q ^ 2'b01);
    assign commit   = qual && is_dir && (state_q == IDLE || (state_q == ACTIVE && !same && !opp));
    assign reject_d = state_q != IDLE && qual_evt && is_dir && opp;
`ifdef KEY_STICKY_EN
    assign release_evt = 1'b0;
`else
    assign release_evt = state_q == ACTIVE && qual && !is_dir;
`endif
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        dir_d   = dir_q;
        valid_d = valid_q;
        cd_d    = cd_q;
        if (state_q == COOL) begin
            cd_d = cd_q - 4'd1;
            if (cd_q == 4'd1) state_d = ACTIVE;
        end
        if (commit) begin
            key_d   = cand_key;
            dir_d   = cand_q[1:0];
            valid_d = 1'b1;
            cd_d    = 4'(COOLDOWN);
            state_d = (COOLDOWN == 0) ? ACTIVE : COOL;
        end else if (release_evt) begin
            key_d   = 16'h0000;
            valid_d = 1'b0;
            state_d = IDLE;
        end
    end
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            k1_q      <= '0;
            k2_q      <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            cd_q      <= '0;
            key_q     <= '0;
            dir_q     <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            k1_q      <= keycode_raw;
            k2_q      <= k1_q;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            cd_q      <= cd_d;
            key_q     <= key_d;
            dir_q     <= dir_d;
            valid_q   <= valid_d;
            changed_q <= commit;
            reject_q  <= reject_d;
        end
    end
    assign key       = key_q;
    assign dir       = dir_q;
    assign dir_valid = valid_q;
    assign changed   = changed_q;
    assign reject    = reject_q;
endmodule

// File: tb/tb_key_dir_filter.sv
// tb_key_dir_filter: directed and random frames checked against a history-based reference model.
module tb_key_dir_filter;
    localparam int HOLD = 2;
    localparam int CD   = 4;
    logic        frame_clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] keycode_raw = 16'h001A;
    logic [15:0] key;
    logic [1:0]  dir;
    logic        dir_valid, changed, reject;
    int n_vec = 0, n_err = 0;
    logic [15:0] key_tab [4] = '{16'h001A, 16'h0016, 16'h0004, 16'h0007};
    // Reference model: classes of sampled keys per edge, run length found by scanning history.
    int          m, pc, pn, last;
    int          rawcls[$], chist[$];
    logic [15:0] e_key;
    logic [1:0]  e_dir;
    logic        e_valid, e_chg, e_rej;
    int          cnt_acc;
    key_dir_filter #(.HOLD_FRAMES(HOLD), .COOLDOWN(CD)) dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode_raw(keycode_raw), .key(key),
        .dir(dir), .dir_valid(dir_valid), .changed(changed), .reject(reject));
    always #5 frame_clk = ~frame_clk;
    function automatic int cls_of(input logic [15:0] v);
        for (int i = 0; i < 4; i++) if (v == key_tab[i]) return i;
        return -1;
    endfunction
    task automatic model_reset();
        m = 0; pc = -1; pn = 0; last = -1000;
        rawcls.delete(); chist.delete();
        e_key = '0; e_dir = '0; e_valid = 0; e_chg = 0; e_rej = 0;
    endtask
    task automatic model_edge(input logic [15:0] v);
        int c, n;
        bit sticky, qual, evt;
`ifdef KEY_STICKY_EN
        sticky = 1;
`else
        sticky = 0;
`endif
        m++;
        e_chg = 0; e_rej = 0;
        qual = pn >= HOLD; evt = pn == HOLD;
        if (e_valid && evt && pc >= 0 && pc == (int'(e_dir) ^ 1)) e_rej = 1;
        if ((!e_valid && qual && pc >= 0) ||
            (e_valid && m > last + CD && qual && pc >= 0 && pc != int'(e_dir) && pc != (int'(e_dir) ^ 1))) begin
            e_key = key_tab[pc]; e_dir = 2'(pc); e_valid = 1; e_chg = 1; last = m;
        end else if (e_valid && m > last + CD && qual && pc < 0 && !sticky) begin
            e_key = '0; e_valid = 0;
        end
        c = (m <= 2) ? -1 : rawcls[m-3];
        rawcls.push_back(cls_of(v));
        chist.push_back(c);
        n = 0;
        for (int i = chist.size() - 1; i >= 0 && chist[i] == c && n < 15; i--) n++;
        pc = c; pn = n;
    endtask
    task automatic xchk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic check_all(input string tag);
        xchk({tag, ".key"}, key, e_key);
        xchk({tag, ".dir"}, 16'(dir), 16'(e_dir));
        xchk({tag, ".dir_valid"}, 16'(dir_valid), 16'(e_valid));
        xchk({tag, ".changed"}, 16'(changed), 16'(e_chg));
        xchk({tag, ".reject"}, 16'(reject), 16'(e_rej));
    endtask
    task automatic step(input logic [15:0] v, input string tag);
        keycode_raw = v;
        @(posedge frame_clk);
        model_edge(v);
        #1 check_all(tag);
    endtask
    task automatic do_reset();
        Reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        xchk("async_reset.key0", key, 16'h0000);
        @(posedge frame_clk);
        #1 check_all("reset_hold");
        Reset = 1'b0;
    endtask
    initial begin
        int rej, chg, r, len;
        logic [15:0] v;
        model_reset();
        repeat (2) begin
            @(posedge frame_clk);
            #1 check_all("in_reset");
        end
        Reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step(16'h001A, "hold_up");
            if (i == 4) xchk("up_not_yet", key, 16'h0000);
        end
        xchk("up_key", key, 16'h001A);
        xchk("up_changed", 16'(changed), 16'h1);
        step(16'h001A, "hold_up");
        xchk("up_changed_drop", 16'(changed), 16'h0);
        repeat (5) step(16'h001A, "up_cool");
        rej = 0;
        repeat (10) begin
            step(16'h0016, "reversal");
            rej += int'(reject);
        end
        xchk("rev_key", key, 16'h001A);
        xchk("rev_pulses", 16'(rej), 16'd1);
        for (int i = 1; i <= 5; i++) begin
            step(16'h0007, "turn_right");
            if (i == 4) xchk("right_not_yet", key, 16'h001A);
        end
        xchk("right_key", key, 16'h0007);
        xchk("right_dir", 16'(dir), 16'd3);
        repeat (6) step(16'h0007, "right_cool");
        repeat (5) step(16'h0000, "release");
`ifdef KEY_STICKY_EN
        xchk("release_key", key, 16'h0007);
`else
        xchk("release_key", key, 16'h0000);
`endif
        do_reset();
        chg = 0;
        step(16'h0004, "glitch");
        chg += int'(changed);
        repeat (8) begin
            step(16'h0000, "glitch_tail");
            chg += int'(changed);
        end
        repeat (10) begin
            step(16'h1234, "bad_code");
            chg += int'(changed);
        end
        xchk("glitch_changes", 16'(chg), 16'd0);
        xchk("glitch_key", key, 16'h0000);
        do_reset();
        repeat (5) step(16'h001A, "cd_up");
        xchk("cd_up_key", key, 16'h001A);
        for (int i = 1; i <= 5; i++) begin
            step(16'h0004, "cd_left");
            if (i < 5) xchk("cd_blocked", key, 16'h001A);
        end
        xchk("cd_left_key", key, 16'h0004);
        step(16'h0004, "cd_in_cool");
        do_reset();
        xchk("mid_cool_valid", 16'(dir_valid), 16'h0);
        repeat (70) begin
            r = $urandom_range(0, 5);
            v = (r < 4) ? key_tab[r] : (r == 4) ? 16'h0000 : 16'($urandom);
            len = $urandom_range(1, 6);
            repeat (len) step(v, "random");
            if ($urandom_range(0, 19) == 0) do_reset();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
